reaction_display_ctrl: RTL and testbench

Sequencer that takes a binary reaction time in milliseconds and drives four 7-segment digits HEX3..HEX0. It latches the value, converts it to BCD serially (shift-add-3, one bit per clock), then shares one hex_to_7seg decoder instance across the four digits, writing one digit register per clock. It sits between the reaction-timer counter and the board HEX pins. Segment outputs are active-low.

---
 rtl/reaction_display_ctrl.sv | 160 ++++++++++++++++
 tb/tb_reaction_display_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_display_ctrl.sv
// Latches a millisecond count, converts it to BCD with serial shift-add-3, then writes
// HEX3..HEX0 through one shared 7-segment decoder. Optional build macro: LEADING_ZERO_BLANK_EN.

module hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    // Active-low segments, bit order {g,f,e,d,c,b,a}
    always_comb begin
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end
endmodule

module reaction_display_ctrl #(
    parameter int                 VALUE_W    = 14,
    parameter logic [VALUE_W-1:0] SAT_VALUE  = 14'd9999,
    parameter logic [6:0]         BLANK_CODE = 7'b1111111
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    input  logic               clear,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3
);
    typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

    state_t             state, state_n;
    logic [VALUE_W-1:0] bin, bin_n;
    logic [15:0]        bcd, bcd_n, bcd_adj;
    logic [3:0]         cnt, cnt_n;
    logic [1:0]         idx, idx_n;
    logic [6:0]         hex   [4];
    logic [6:0]         hex_n [4];
    logic               done_n, ovf_n;
    logic [3:0]         nibble;
    logic [6:0]         seg, digit_code;

    assign nibble = bcd[{idx, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .hex (nibble),
        .seg (seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more significant digit are zero; HEX0 always lit.
    assign digit_code = ((idx != 2'd0) && ((bcd >> {idx, 2'b00}) == 16'd0)) ? BLANK_CODE : seg;
`else
    assign digit_code = seg;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
    end

    assign busy = (state != IDLE);
    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign HEX3 = hex[3];

    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_n = state;
        bin_n   = bin;
        bcd_n   = bcd;
        cnt_n   = cnt;
        idx_n   = idx;
        hex_n   = hex;
        done_n  = 1'b0;
        ovf_n   = ovf;

        case (state)
            IDLE: begin
                if (load) begin
                    bin_n   = (value > SAT_VALUE) ? SAT_VALUE : value;
                    ovf_n   = (value > SAT_VALUE);
                    bcd_n   = '0;
                    cnt_n   = '0;
                    state_n = CONV;
                end
            end
            CONV: begin
                {bcd_n, bin_n} = {bcd_adj, bin} << 1;
                cnt_n          = cnt + 4'd1;
                if (cnt == 4'(VALUE_W - 1)) begin
                    idx_n   = 2'd3;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                hex_n[idx] = digit_code;
                if (idx == 2'd0) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    idx_n = idx - 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Clear is last so it overrides a simultaneous load or an in-flight final write.
        if (clear) begin
            state_n = IDLE;
            done_n  = 1'b0;
            ovf_n   = 1'b0;
            for (int i = 0; i < 4; i++) hex_n[i] = BLANK_CODE;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            idx   <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            for (int i = 0; i < 4; i++) hex[i] <= BLANK_CODE;
        end else begin
            state <= state_n;
            bin   <= bin_n;
            bcd   <= bcd_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            done  <= done_n;
            ovf   <= ovf_n;
            hex   <= hex_n;
        end
    end
endmodule

// File: tb/tb_reaction_display_ctrl.sv
// Self-checking bench for reaction_display_ctrl: vector table, corner-case sequences and
// randomized values compared against a decimal-arithmetic display model.

module tb_reaction_display_ctrl;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0011000};
    localparam int POW10 [4] = '{1, 10, 100, 1000};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = BLK;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic [13:0] value;
    logic        load, clear;
    logic        busy, done, ovf;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         v;
        logic [6:0] h3, h2, h1, h0;
        logic       ovf;
    } vec_t;

    reaction_display_ctrl dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .value    (value),
        .load     (load),
        .clear    (clear),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    // Display model: clamp, split into decimal digits, optionally darken leading zeros.
    function automatic logic [6:0] model_digit(input int v, input int d);
        int c;
        c = (v > 9999) ? 9999 : v;
`ifdef LEADING_ZERO_BLANK_EN
        if (d != 0 && c < POW10[d]) return BLK;
`endif
        return SEG[(c / POW10[d]) % 10];
    endfunction

    task automatic check_hex(input string tag, input logic [6:0] e3, e2, e1, e0, input logic eo);
        check({tag, "_hex3"}, HEX3, e3);
        check({tag, "_hex2"}, HEX2, e2);
        check({tag, "_hex1"}, HEX1, e1);
        check({tag, "_hex0"}, HEX0, e0);
        check({tag, "_ovf"}, ovf, eo);
    endtask

    task automatic check_model(input string tag, input int v);
        check_hex(tag, model_digit(v, 3), model_digit(v, 2), model_digit(v, 1),
                  model_digit(v, 0), v > 9999);
    endtask

    // Called at a falling edge; the next rising edge is the load edge k.
    task automatic do_load(input int v);
        value = 14'(v);
        load  = 1'b1;
        @(negedge CLOCK_50);
        load  = 1'b0;
    endtask

    // Counts rising edges after the load edge until done is seen; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLOCK_50);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Full transaction: load, latency 18, busy drop and single-cycle done.
    task automatic transact(input string tag, input int v, output bit ok);
        int cyc;
        do_load(v);
        check({tag, "_busy_set"}, busy, 1'b1);
        wait_done(cyc);
        check({tag, "_latency"}, cyc, 18);
        ok = (cyc > 0);
        if (ok) check({tag, "_busy_clr"}, busy, 1'b0);
    endtask

    task automatic done_falls(input string tag);
        @(negedge CLOCK_50);
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        vec_t vecs[$];
        bit   ok;
        int   cyc, pulses, v;

        vecs.push_back('{1234,  7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 1'b0});
        vecs.push_back('{12000, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000, 1'b1});
        vecs.push_back('{5,     LZ,         LZ,         LZ,         7'b0010010, 1'b0});
        vecs.push_back('{7,     LZ,         LZ,         LZ,         7'b1111000, 1'b0});
        vecs.push_back('{0,     LZ,         LZ,         LZ,         7'b1000000, 1'b0});
        vecs.push_back('{9999,  7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000, 1'b0});
        vecs.push_back('{10000, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000, 1'b1});
        vecs.push_back('{16383, 7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000, 1'b1});
        vecs.push_back('{1000,  7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000, 1'b0});
        vecs.push_back('{305,   LZ,         7'b0110000, 7'b1000000, 7'b0010010, 1'b0});
        vecs.push_back('{8888,  7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0});

        RESET = 1'b1;
        value = '0;
        load  = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check_hex("reset", BLK, BLK, BLK, BLK, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        RESET = 1'b0;
        @(negedge CLOCK_50);

        foreach (vecs[i]) begin
            transact($sformatf("vec%0d", vecs[i].v), vecs[i].v, ok);
            if (ok) begin
                check_hex($sformatf("vec%0d", vecs[i].v), vecs[i].h3, vecs[i].h2, vecs[i].h1,
                          vecs[i].h0, vecs[i].ovf);
                done_falls($sformatf("vec%0d", vecs[i].v));
            end
        end

        // Second load at edge k+5 is ignored; load right at done (edge k+19) is accepted.
        do_load(1234);
        repeat (4) @(negedge CLOCK_50);
        do_load(8888);
        check("ign_busy", busy, 1'b1);
        wait_done(cyc);
        check("ign_latency", cyc, 13);
        if (cyc > 0) begin
            check_hex("ign", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 1'b0);
            value = 14'd8888;
            load  = 1'b1;
            @(negedge CLOCK_50);
            load  = 1'b0;
            check("b2b_accept", busy, 1'b1);
            check("b2b_done_pulse", done, 1'b0);
            wait_done(cyc);
            check("b2b_latency", cyc, 18);
            check_hex("b2b", 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0);
            done_falls("b2b");
        end

        // Clear at edge k+10 aborts the conversion with no done pulse.
        transact("pre_clr", 12000, ok);
        done_falls("pre_clr");
        do_load(5678);
        repeat (9) @(negedge CLOCK_50);
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        check("clr_busy", busy, 1'b0);
        check_hex("clr", BLK, BLK, BLK, BLK, 1'b0);
        pulses = 0;
        repeat (25) begin
            @(negedge CLOCK_50);
            if (done) pulses++;
        end
        check("clr_no_done", pulses, 0);

        // Clear and load on the same edge: load dropped.
        value = 14'd1234;
        load  = 1'b1;
        clear = 1'b1;
        @(negedge CLOCK_50);
        load  = 1'b0;
        clear = 1'b0;
        check("clrld_busy", busy, 1'b0);
        pulses = 0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (done || busy) pulses++;
        end
        check("clrld_idle", pulses, 0);
        check_hex("clrld", BLK, BLK, BLK, BLK, 1'b0);

        // Asynchronous reset between edges mid-conversion.
        transact("pre_rst", 12000, ok);
        done_falls("pre_rst");
        do_load(300);
        repeat (3) @(negedge CLOCK_50);
        #2 RESET = 1'b1;
        #1;
        check_hex("arst", BLK, BLK, BLK, BLK, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        @(negedge CLOCK_50);
        transact("post_rst", 42, ok);
        if (ok) check_model("post_rst", 42);
        done_falls("post_rst");

        // Randomized values against the model.
        for (int n = 0; n < 30; n++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383))
                                            : int'($urandom_range(0, 9999));
            repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
            transact($sformatf("rnd%0d", v), v, ok);
            if (ok) begin
                check_model($sformatf("rnd%0d", v), v);
                done_falls($sformatf("rnd%0d", v));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
